// File: rtl/tmds_link_ctrl.sv
// TMDS output link bring-up/supervision: lock filtering, serializer reset sequencing,
// idle-token settle period and gating of encoder symbols onto the three channels.
module tmds_link_ctrl #(
  parameter int         RST_CYCLES    = 16,
  parameter int         SETTLE_CYCLES = 1024,
  parameter int         LOCK_FILTER   = 8,
  parameter logic [9:0] IDLE_SYMBOL   = 10'b1101010100
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart_req,
  input  logic [9:0] enc_data_0,
  input  logic [9:0] enc_data_1,
  input  logic [9:0] enc_data_2,
  output logic [9:0] tmds_data_0,
  output logic [9:0] tmds_data_1,
  output logic [9:0] tmds_data_2,
  output logic       serdes_rst,
  output logic       link_up,
  output logic [7:0] lock_lost_cnt
);

  localparam int MAX_A   = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > LOCK_FILTER) ? MAX_A : LOCK_FILTER;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK  = 2'd0,
    SERDES_RST = 2'd1,
    SETTLE     = 2'd2,
    ACTIVE     = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       lost_reg, lost_next;
  logic             lock_meta_reg, lock_s_reg;
  logic             serdes_rst_reg, link_up_reg;
  logic [9:0]       enc_arr [3];
  logic [9:0]       tmds_reg [3];

  assign enc_arr[0] = enc_data_0;
  assign enc_arr[1] = enc_data_1;
  assign enc_arr[2] = enc_data_2;

  // pll_locked is asynchronous to clk_pix; lock_s is the only consumer-facing copy.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    lost_next  = lost_reg;
    case (state_reg)
      WAIT_LOCK: begin
        if (!lock_s_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == LOCK_TC) begin
          state_next = SERDES_RST;
          cnt_next   = '0;
        end
      end
      SERDES_RST: begin
        if (!lock_s_reg) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == RST_TC) begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
      end
      SETTLE, ACTIVE: begin
        if (state_reg == ACTIVE) cnt_next = '0;
        if (!lock_s_reg) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
          if (lost_reg != 8'hFF) lost_next = lost_reg + 8'd1;
        end else if (restart_req) begin
          state_next = SERDES_RST;
          cnt_next   = '0;
        end else if (state_reg == SETTLE && cnt_reg == SETTLE_TC) begin
          state_next = ACTIVE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Status flags follow the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state_reg      <= WAIT_LOCK;
      cnt_reg        <= '0;
      lost_reg       <= 8'd0;
      serdes_rst_reg <= 1'b1;
      link_up_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      lost_reg       <= lost_next;
      serdes_rst_reg <= (state_next == WAIT_LOCK) || (state_next == SERDES_RST);
      link_up_reg    <= (state_next == ACTIVE);
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      always_ff @(posedge clk_pix) begin
        if (rst) begin
          tmds_reg[gi] <= IDLE_SYMBOL;
        end else begin
          tmds_reg[gi] <= (state_reg == ACTIVE) ? enc_arr[gi] : IDLE_SYMBOL;
        end
      end
    end
  endgenerate

  assign tmds_data_0   = tmds_reg[0];
  assign tmds_data_1   = tmds_reg[1];
  assign tmds_data_2   = tmds_reg[2];
  assign serdes_rst    = serdes_rst_reg;
  assign link_up       = link_up_reg;
  assign lock_lost_cnt = lost_reg;

endmodule
